// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter
//   Round-robin arbiter in front of a shared 4:1 bus mux. One requester at a
//   time is granted. Its select code and data word are registered and held on a
//   valid/ready port until the sink accepts the word. The winner is then
//   acknowledged with a one-cycle ack pulse.
//
// Ports
//   clk, rst_n     rising-edge clock, asynchronous active-low reset
//   req[3:0]       request per requester (bit i <-> Di)
//   D0..D3         requester data words
//   ack[3:0]       one-hot, one-cycle pulse: word of requester i accepted
//   sel[1:0]       grant index, steers the shared mux; changes only on grant
//   Y              registered output word
//   out_valid      Y holds a granted word
//   out_ready      sink accepts Y this cycle
//   busy           a grant is outstanding
module mux_rr_arbiter #(
    parameter int BUS_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [3:0]           req,
    input  logic [BUS_WIDTH-1:0] D0,
    input  logic [BUS_WIDTH-1:0] D1,
    input  logic [BUS_WIDTH-1:0] D2,
    input  logic [BUS_WIDTH-1:0] D3,
    output logic [3:0]           ack,
    output logic [1:0]           sel,
    output logic [BUS_WIDTH-1:0] Y,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t               state, state_nxt;
    logic [1:0]           last;
    logic [1:0]           winner;
    logic                 found;
    logic [BUS_WIDTH-1:0] d_win;

    // Search upward from last+1. Offset 4 truncates to 0, so the previous
    // winner is looked at last and gets the lowest priority.
    always_comb begin
        winner = 2'd0;
        found  = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            logic [1:0] idx;
            idx = last + k[1:0];
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        case (winner)
            2'd0:    d_win = D0;
            2'd1:    d_win = D1;
            2'd2:    d_win = D2;
            default: d_win = D3;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (found)     state_nxt = GRANT;
            GRANT:   if (out_ready) state_nxt = IDLE;  // out_valid is 1 throughout GRANT
            default: state_nxt = IDLE;
        endcase
    end

    // Registered outputs. A reset during GRANT clears everything, so the
    // in-flight word is dropped without an ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel       <= 2'd0;
            Y         <= '0;
            out_valid <= 1'b0;
            ack       <= 4'b0000;
            busy      <= 1'b0;
            last      <= 2'd3;
        end else begin
            ack <= 4'b0000;
            case (state)
                IDLE: begin
                    if (found) begin
                        sel       <= winner;
                        Y         <= d_win;
                        out_valid <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                GRANT: begin
                    if (out_ready) begin
                        ack       <= 4'b0001 << sel;
                        last      <= sel;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed testbench for mux_rr_arbiter. Inputs change and outputs are sampled
// 1 time unit after each rising edge.
module tb_mux_rr_arbiter;

    localparam int BW = 5;

    logic          clk;
    logic          rst_n;
    logic [3:0]    req;
    logic [BW-1:0] D0, D1, D2, D3;
    logic [3:0]    ack;
    logic [1:0]    sel;
    logic [BW-1:0] Y;
    logic          out_valid;
    logic          out_ready;
    logic          busy;

    int checks   = 0;
    int failures = 0;

    mux_rr_arbiter #(.BUS_WIDTH(BW)) dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .D0(D0), .D1(D1), .D2(D2), .D3(D3),
        .ack(ack), .sel(sel), .Y(Y), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full output snapshot: sel, Y, out_valid, ack, busy.
    task automatic chk_all(input string tag, input int e_sel, input int e_y,
                           input int e_vld, input int e_ack, input int e_busy);
        chk({tag, ".sel"},       32'(sel),       e_sel);
        chk({tag, ".Y"},         32'(Y),         e_y);
        chk({tag, ".out_valid"}, 32'(out_valid), e_vld);
        chk({tag, ".ack"},       32'(ack),       e_ack);
        chk({tag, ".busy"},      32'(busy),      e_busy);
    endtask

    initial begin
        int rr_order [5];
        int dv [4];
        dv = '{5'h01, 5'h0A, 5'h13, 5'h1C};
        rr_order = '{0, 1, 2, 3, 0};

        // Reset held with all requests up
        rst_n = 1'b0; req = 4'b1111; out_ready = 1'b0;
        D0 = 5'(dv[0]); D1 = 5'(dv[1]); D2 = 5'(dv[2]); D3 = 5'(dv[3]);
        step(); step();
        chk_all("reset", 0, 0, 0, 0, 0);

        // Idle after release: nothing changes
        rst_n = 1'b1; req = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            step();
            chk_all("idle", 0, 0, 0, 0, 0);
        end

        // Single requester 2
        req = 4'b0100; D2 = 5'h15; out_ready = 1'b1;
        step();
        chk_all("single.grant", 2, 'h15, 1, 0, 1);
        step();
        chk_all("single.ack", 2, 'h15, 0, 4, 0);
        req = 4'b0000;
        step();
        chk_all("single.after", 2, 'h15, 0, 0, 0);

        // Fresh reset so round robin starts from requester 0
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        D2 = 5'(dv[2]);
        req = 4'b1111; out_ready = 1'b1;
        foreach (rr_order[i]) begin
            step();
            chk_all($sformatf("rr%0d.grant", i), rr_order[i], dv[rr_order[i]], 1, 0, 1);
            step();
            chk_all($sformatf("rr%0d.ack", i), rr_order[i], dv[rr_order[i]], 0, 1 << rr_order[i], 0);
        end
        req = 4'b0000;
        step();
        chk("rr.ack_clear", 32'(ack), 0);

        // Backpressure on requester 1 (last = 0)
        req = 4'b0010; D1 = 5'h0A; out_ready = 1'b0;
        step();
        chk_all("bp.grant", 1, 'h0A, 1, 0, 1);
        for (int i = 0; i < 6; i++) begin
            D1 = 5'(5'h10 + i);
            step();
            chk_all($sformatf("bp.hold%0d", i), 1, 'h0A, 1, 0, 1);
        end
        out_ready = 1'b1;
        step();
        chk_all("bp.ack", 1, 'h0A, 0, 2, 0);
        req = 4'b0000; D1 = 5'(dv[1]);
        step();

        // Set last = 2, then req 0011 -> 0 (wrap, skip 3) then 1
        req = 4'b0100;
        step();
        chk("wrap.pre.sel", 32'(sel), 2);
        step();
        chk("wrap.pre.ack", 32'(ack), 4);
        req = 4'b0011;
        step();
        chk_all("wrap.g0", 0, dv[0], 1, 0, 1);
        step();
        chk("wrap.g0.ack", 32'(ack), 1);
        req = 4'b0010;
        step();
        chk_all("wrap.g1", 1, dv[1], 1, 0, 1);
        step();
        chk("wrap.g1.ack", 32'(ack), 2);
        req = 4'b0000;
        step();

        // Async reset in the middle of a grant (last = 1 -> winner 3)
        req = 4'b1000; out_ready = 1'b0;
        step();
        chk_all("ar.grant", 3, dv[3], 1, 0, 1);
        #2 rst_n = 1'b0;
        #1;
        chk_all("ar.async", 0, 0, 0, 0, 0);
        out_ready = 1'b1;
        step();
        chk_all("ar.held", 0, 0, 0, 0, 0);
        #2 rst_n = 1'b1; req = 4'b1010; out_ready = 1'b0;
        step();
        chk_all("ar.regrant", 1, dv[1], 1, 0, 1);
        out_ready = 1'b1;
        step();
        chk_all("ar.ack", 1, dv[1], 0, 2, 0);
        req = 4'b0000;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
